vend_controller: RTL
====================

// Module: vend_controller
// PURPOSE
// - Transaction FSM directly downstream of the item-select encoder. Consumes its 3-bit item cost,
//   accumulates coin credit and issues a one-cycle dispense pulse once credit covers the price.
// - Returns change or a full refund over a valid/ack handshake to the coin-return mechanism.
// - Sits between the front-panel encoders (item, coin) and the dispense/return actuators.
// PARAMETERS
// - COST_W       3    width of item_cost (matches item encoder output)
// - CREDIT_W     4    width of credit/change registers; credit saturates at 2**CREDIT_W-1
// - TIMEOUT_CYC  1000 idle cycles in COLLECT before automatic refund (>=2)
// PORTS
// - clk          in   1         single clock; all state on rising edge
// - rst_n        in   1         asynchronous, active-low reset
// - item_valid   in   1         one-cycle strobe: item_cost holds a selection
// - item_cost    in   COST_W    price in coin units; 0 = no item
// - coin_valid   in   1         one-cycle strobe: one coin inserted
// - coin_value   in   2         coin worth in units (0 ignored, 1..3)
// - cancel       in   1         customer abort request (level, sampled each cycle)
// - change_ack   in   1         return mechanism has taken change_amt
// - dispense     out  1         one-cycle pulse: release item
// - change_valid out  1         change_amt valid; held until change_ack
// - change_amt   out  CREDIT_W  coins to return
// - credit       out  CREDIT_W  current credit, for display
// - busy         out  1         high in every state except IDLE
// BEHAVIOUR
// - Clock and reset: one clock; reset is asynchronous and active-low.
// - Reset: state=IDLE. price, credit, change_amt and timer = 0. dispense, change_valid, busy = 0.
// - All outputs are registered and Moore-style; no combinational input-to-output path.
// - IDLE
//   - item_valid with item_cost!=0: latch price<=item_cost and go to COLLECT; credit stays 0.
//   - item_valid with item_cost==0: ignored.
//   - Coins and cancel in IDLE are ignored (the mechanism rejects coins when busy=0).
// - COLLECT
//   - coin_valid && coin_value!=0: credit <= sat(credit+coin_value) and timer reset to 0.
//   - Otherwise the timer increments.
//   - Transition priority, evaluated on registered values each cycle:
//     - 1: cancel, or timer==TIMEOUT_CYC-1 -> REFUND.
//       A coin arriving in the same cycle is still added and is included in the refund.
//     - 2: credit >= price (registered credit) -> DISPENSE.
//       Latency: the coin that completes the price at edge N gives dispense=1 in cycle N+1.
//   - item_valid in COLLECT is ignored; the price cannot change mid-transaction.
// - DISPENSE (exactly 1 cycle)
//   - dispense=1; change_amt <= credit-price (never negative, since credit>=price).
//   - Coins arriving in this cycle are rejected and not added.
//   - Next state: CHANGE if credit>price, else IDLE with credit<=0.
// - CHANGE and REFUND (share one handshake)
//   - change_valid=1. change_amt is stable: credit-price for CHANGE, full credit for REFUND.
//   - Leave on change_ack: go to IDLE; credit, change_amt and price <= 0; change_valid drops
//     next cycle.
//   - change_ack while change_valid=0 is ignored.
//   - cancel, coins and item_valid are ignored while waiting for change_ack.
// - Saturation: credit clamps at 2**CREDIT_W-1. Excess coin value is lost; no wrap-around.
// - Reset mid-transaction: credit is lost and the FSM returns to IDLE immediately, asynchronously.
//   No dispense or change is issued for the aborted transaction.
// STRUCTURE
// - Package vend_pkg holds:
//   - typedef enum logic [2:0] vend_state_t {IDLE, COLLECT, DISPENSE, CHANGE, REFUND}
//   - localparams COST_W and CREDIT_W
//   - typedefs cost_t and credit_t
// - Sub-module vend_credit_acc: saturating credit add/clear plus inactivity timer; the FSM
//   drives its add, clear and timer-reset controls.
// - The FSM is a two-process design: state register plus next-state/output logic.
// TESTING
// - Exact pay: cost=3, coins 1,2 -> dispense pulse 1 cycle after 2nd coin, change_valid never set,
//   IDLE after.
// - Overpay: cost=5, coins 3,3 -> dispense, then change_valid=1 with change_amt=1 held until ack,
//   then IDLE.
// - Cancel with coin: cost=5, coin 2, then cancel plus coin 1 in the same cycle
//   -> REFUND, change_amt=3, no dispense.
// - Timeout: TIMEOUT_CYC=8, cost=2, coin 1, no further input -> REFUND with change_amt=1 after
//   8 cycles.
// - Saturation/ignore: credit 14, coin 3 -> credit=15. item_valid cost=1 during COLLECT leaves
//   price unchanged. cost=0 strobe in IDLE -> stays IDLE.
// - Async reset in CHANGE before ack: outputs go to 0 without a clock edge; next transaction
//   proceeds normally.

Source files
------------

// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending transaction controller.
//   COST_W / CREDIT_W : default widths of the item price and the coin credit
//   cost_t / credit_t : convenience types at those default widths
//   vend_state_t      : transaction FSM states
// -----------------------------------------------------------------------------
package vend_pkg;

   localparam int COST_W   = 3;
   localparam int CREDIT_W = 4;

   typedef logic [COST_W-1:0]   cost_t;
   typedef logic [CREDIT_W-1:0] credit_t;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      DISPENSE,
      CHANGE,
      REFUND
   } vend_state_t;

endpackage

// File: rtl/vend_credit_acc.sv
// -----------------------------------------------------------------------------
// vend_credit_acc
// Saturating coin-credit accumulator plus the COLLECT inactivity timer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   add          : add add_value to the credit (saturating)
//   add_value    : coin worth in units
//   clear        : zero the credit
//   timer_clr    : restart the inactivity timer, otherwise it counts up
//   credit       : registered credit
//   credit_next  : value the credit register takes at the next edge
//   timer        : registered inactivity count
// -----------------------------------------------------------------------------
module vend_credit_acc
   import vend_pkg::*;
#(
   parameter int CREDIT_W = vend_pkg::CREDIT_W,
   parameter int TIMER_W  = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                add,
   input  logic [1:0]          add_value,
   input  logic                clear,
   input  logic                timer_clr,
   output logic [CREDIT_W-1:0] credit,
   output logic [CREDIT_W-1:0] credit_next,
   output logic [TIMER_W-1:0]  timer
);

   localparam int SUM_W = CREDIT_W + 1;

   logic [SUM_W-1:0]    sum;
   logic [CREDIT_W-1:0] sum_sat;

   // The sum is one bit wider than the credit so an overflow shows up in the
   // top bit; when it does, the credit pins at all-ones and the excess coin
   // value is simply dropped rather than wrapping.
   always_comb begin
      sum     = {1'b0, credit} + SUM_W'(add_value);
      sum_sat = sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
      if (clear) begin
         credit_next = '0;
      end else if (add) begin
         credit_next = sum_sat;
      end else begin
         credit_next = credit;
      end
   end

   // Credit register; credit_next is exported so the FSM can capture the
   // exact amount a refund must return, including a coin landing that edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit <= '0;
      end else begin
         credit <= credit_next;
      end
   end

   // Inactivity timer: held at zero outside COLLECT and on every accepted
   // coin, free-running otherwise. The FSM leaves COLLECT before it wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (timer_clr) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

endmodule

// File: rtl/vend_controller.sv
// -----------------------------------------------------------------------------
// vend_controller
// Vending transaction FSM: latches an item price, collects coin credit,
// pulses dispense once credit covers the price, and returns change or a full
// refund over a valid/ack handshake.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   item_valid   : strobe, item_cost holds a selection (0 = no item)
//   item_cost    : price in coin units
//   coin_valid   : strobe, one coin of coin_value units inserted (0 ignored)
//   cancel       : customer abort, level sampled each cycle
//   change_ack   : return mechanism has taken change_amt
//   dispense     : one-cycle release pulse
//   change_valid : change_amt valid, held until change_ack
//   change_amt   : coins to return
//   credit       : current credit for the display
//   busy         : high in every state except IDLE
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module vend_controller
   import vend_pkg::*;
#(
   parameter int COST_W      = vend_pkg::COST_W,
   parameter int CREDIT_W    = vend_pkg::CREDIT_W,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                item_valid,
   input  logic [COST_W-1:0]   item_cost,
   input  logic                coin_valid,
   input  logic [1:0]          coin_value,
   input  logic                cancel,
   input  logic                change_ack,
   output logic                dispense,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amt,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam int                 TIMER_W    = $clog2(TIMEOUT_CYC);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

   vend_state_t         state;
   vend_state_t         state_next;
   logic [COST_W-1:0]   price;
   logic [CREDIT_W-1:0] price_ext;
   logic [CREDIT_W-1:0] credit_next;
   logic [TIMER_W-1:0]  timer;
   logic                coin_ok;
   logic                add_en;
   logic                clear_en;
   logic                timer_clr;
   logic                load_price;

   assign coin_ok   = coin_valid && (coin_value != 2'd0);
   assign price_ext = CREDIT_W'(price);

   vend_credit_acc #(
      .CREDIT_W (CREDIT_W),
      .TIMER_W  (TIMER_W)
   ) u_credit_acc (
      .clk         (clk),
      .rst_n       (rst_n),
      .add         (add_en),
      .add_value   (coin_value),
      .clear       (clear_en),
      .timer_clr   (timer_clr),
      .credit      (credit),
      .credit_next (credit_next),
      .timer       (timer)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and accumulator control. Coins only count in COLLECT, so the
   // accumulator is left alone everywhere else. In COLLECT the abort paths
   // win over a completed payment, and both look at the registered credit,
   // which is why a completing coin shows up as dispense one cycle later.
   always_comb begin
      state_next = state;
      add_en     = 1'b0;
      clear_en   = 1'b0;
      timer_clr  = 1'b1;
      load_price = 1'b0;
      case (state)
         IDLE: begin
            if (item_valid && (item_cost != '0)) begin
               load_price = 1'b1;
               state_next = COLLECT;
            end
         end
         COLLECT: begin
            add_en    = coin_ok;
            timer_clr = coin_ok;
            if (cancel || (timer == TIMER_LAST)) begin
               state_next = REFUND;
            end else if (credit >= price_ext) begin
               state_next = DISPENSE;
            end
         end
         DISPENSE: begin
            if (credit > price_ext) begin
               state_next = CHANGE;
            end else begin
               state_next = IDLE;
               clear_en   = 1'b1;
            end
         end
         CHANGE, REFUND: begin
            if (change_ack) begin
               state_next = IDLE;
               clear_en   = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            clear_en   = 1'b1;
         end
      endcase
   end

   // The price is frozen for the whole transaction and only forgotten once
   // the customer has been fully settled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         price <= '0;
      end else if (load_price) begin
         price <= item_cost;
      end else if (clear_en) begin
         price <= '0;
      end
   end

   // Status outputs are decoded from the next state and registered, so they
   // line up with the state they describe without any input-to-output path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dispense     <= 1'b0;
         change_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         dispense     <= (state_next == DISPENSE);
         change_valid <= (state_next == CHANGE) || (state_next == REFUND);
         busy         <= (state_next != IDLE);
      end
   end

   // Change amount: the overpayment is computed during the dispense cycle
   // while credit and price are both stable. A refund captures credit_next
   // rather than credit so a coin arriving alongside the cancel/timeout is
   // returned as well. Either way it then holds until the ack clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         change_amt <= '0;
      end else if (state == DISPENSE) begin
         change_amt <= credit - price_ext;
      end else if ((state == COLLECT) && (state_next == REFUND)) begin
         change_amt <= credit_next;
      end else if (clear_en) begin
         change_amt <= '0;
      end
   end

endmodule
